// File: rtl/lane_scatter_pkg.sv
// lane_scatter_pkg: shared constants and helpers for the lane scatter block.
package lane_scatter_pkg;

  localparam int DROP_CNT_W = 16;

  // Lane index width; a single-bit index is kept even for one or two lanes.
  function automatic int lane_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_scatter_fifo.sv
// lane_scatter_fifo: per-lane FIFO with wrap-bit pointers and a registered head.
module lane_scatter_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr, rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push, do_pop;

  // Extra MSB on each pointer tells full apart from empty.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rptr[AW-1:0]];

  // Pointer update; both may move in the same cycle, keeping occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is only visible while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lane_scatter.sv
// lane_scatter: routes an indexed beat stream into per-lane FIFOs.
// Optional macro LANE_SCATTER_BYPASS_EN: a beat to an empty lane whose
// consumer is ready is forwarded combinationally instead of being queued.
module lane_scatter
  import lane_scatter_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 2,
  localparam int IDX_W     = lane_idx_w(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IDX_W-1:0]            in_idx,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  input  logic                        err_clr,
  output logic [DROP_CNT_W-1:0]       drop_cnt,
  output logic                        err_sticky
);

  localparam logic [IDX_W:0] LANES = (IDX_W+1)'(NUM_LANES);

  logic                             in_range, accept, drop;
  logic [NUM_LANES-1:0]             sel, full, empty, push, pop, byp;
  logic [NUM_LANES-1:0][DATA_W-1:0] head;

  assign in_range = ({1'b0, in_idx} < LANES);

  // One-hot lane decode; all-zero when the index is out of range.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_LANES; k++)
      sel[k] = in_range && (in_idx == IDX_W'(k));
  end

  // Out-of-range beats are always taken (and dropped); in-range beats
  // wait for room in their lane, with no credit for a same-cycle pop.
  assign in_ready = !in_range || (rst_n && !(|(sel & full)));
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_range;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
`ifdef LANE_SCATTER_BYPASS_EN
    assign byp[k] = accept && sel[k] && empty[k] && out_ready[k];
`else
    assign byp[k] = 1'b0;
`endif
    assign push[k]      = accept && sel[k] && !byp[k];
    assign pop[k]       = out_ready[k] && !empty[k];
    assign out_valid[k] = !empty[k] || byp[k];
    assign out_data[k*DATA_W +: DATA_W] = !empty[k] ? head[k] :
                                          (byp[k] ? in_data : '0);

    lane_scatter_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .push_data (in_data),
      .pop       (pop[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .head_data (head[k])
    );
  end

  // Saturating drop counter and sticky error; a new drop beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      if (drop)         err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_scatter.sv
// tb_lane_scatter: two instances (4 lanes and 3 lanes) checked every cycle
// against per-lane queue models, with directed and random traffic.
module tb_lane_scatter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 drives the 4-lane DUT, 1 the 3-lane DUT.
  logic       iv[2];
  logic [1:0] ix[2];
  logic [7:0] idat[2];
  logic [3:0] ordy[2];
  logic       eclr[2];

  logic        ir4, ir3, es4, es3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [15:0] dc4, dc3;

  lane_scatter #(.NUM_LANES(4), .DATA_W(8), .DEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4), .in_idx(ix[0]),
    .in_data(idat[0]), .out_valid(ov4), .out_ready(ordy[0]), .out_data(od4),
    .err_clr(eclr[0]), .drop_cnt(dc4), .err_sticky(es4));

  lane_scatter #(.NUM_LANES(3), .DATA_W(8), .DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir3), .in_idx(ix[1]),
    .in_data(idat[1]), .out_valid(ov3), .out_ready(ordy[1][2:0]), .out_data(od3),
    .err_clr(eclr[1]), .drop_cnt(dc3), .err_sticky(es3));

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per lane (index d*4+k), drop count, sticky.
  logic [7:0] mq[8][$];
  int         mdrop[2];
  bit         mstk[2];
  bit         e_ir[2], e_byp[2];
  logic [3:0] e_ov[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [1:0] idx,
                       input logic [7:0] data, input logic [3:0] rdy, input logic clr);
    iv[d] = v; ix[d] = idx; idat[d] = data; ordy[d] = rdy; eclr[d] = clr;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mq[i].delete();
    mdrop[0] = 0; mdrop[1] = 0; mstk[0] = 0; mstk[1] = 0;
  endtask

  // Let inputs settle, derive expectations from the model, compare outputs.
  task automatic settle();
    #1;
    for (int d = 0; d < 2; d++) begin
      int          n;
      bit          inr;
      logic [3:0]  ev;
      logic [31:0] ed, aov, aod;
      n = (d == 0) ? 4 : 3;
      ev = '0; ed = '0; e_byp[d] = 0;
      for (int k = 0; k < n; k++)
        if (mq[d*4+k].size() > 0) begin
          ev[k] = 1'b1;
          ed[k*8 +: 8] = mq[d*4+k][0];
        end
      inr = int'(ix[d]) < n;
      e_ir[d] = !inr || (rst_n && mq[d*4+int'(ix[d])].size() < 2);
`ifdef LANE_SCATTER_BYPASS_EN
      if (iv[d] && inr && e_ir[d] && !ev[ix[d]] && ordy[d][ix[d]]) begin
        ev[ix[d]] = 1'b1;
        ed[int'(ix[d])*8 +: 8] = idat[d];
        e_byp[d] = 1;
      end
`endif
      e_ov[d] = ev;
      aov = (d == 0) ? {28'h0, ov4} : {29'h0, ov3};
      aod = (d == 0) ? od4 : {8'h0, od3};
      chk($sformatf("d%0d_in_ready", d), (d == 0) ? ir4 : ir3, e_ir[d]);
      chk($sformatf("d%0d_out_valid", d), aov, {28'h0, ev});
      chk($sformatf("d%0d_out_data", d), aod, ed);
      chk($sformatf("d%0d_drop_cnt", d), (d == 0) ? dc4 : dc3, mdrop[d]);
      chk($sformatf("d%0d_err_sticky", d), (d == 0) ? es4 : es3, mstk[d]);
    end
  endtask

  // Clock edge: apply pops, pushes and drops to the model.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int n;
      bit inr, acc;
      n = (d == 0) ? 4 : 3;
      inr = int'(ix[d]) < n;
      acc = iv[d] && e_ir[d];
      for (int k = 0; k < n; k++)
        if (e_ov[d][k] && ordy[d][k] && !(e_byp[d] && int'(ix[d]) == k))
          void'(mq[d*4+k].pop_front());
      if (acc && !inr) begin
        if (mdrop[d] < 65535) mdrop[d]++;
        mstk[d] = 1;
      end else begin
        if (acc && !e_byp[d]) mq[d*4+int'(ix[d])].push_back(idat[d]);
        if (eclr[d]) mstk[d] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_all(input logic [3:0] rdy);
    drive(0, 0, 0, 0, rdy, 0);
    drive(1, 0, 0, 0, rdy, 0);
  endtask

  initial begin
    idle_all(4'h0);
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state: in-range index not ready, out-of-range index ready.
    drive(1, 0, 2'd3, 0, 0, 0);
    settle();
    chk("rst_ir_oor", ir3, 1'b1);
    chk("rst_ov", {ov3, ov4}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat to lane 2.
    idle_all(4'hF);
    drive(0, 1, 2'd2, 8'hA5, 4'hF, 0);
    settle();
`ifdef LANE_SCATTER_BYPASS_EN
    chk("t1_ov_same", ov4, 4'b0100);
`else
    chk("t1_ov_same", ov4, 4'b0000);
`endif
    tick();
    drive(0, 0, 0, 0, 4'hF, 0);
    settle();
`ifndef LANE_SCATTER_BYPASS_EN
    chk("t1_ov_next", ov4, 4'b0100);
    chk("t1_data", od4[23:16], 8'hA5);
`endif
    tick();
    step();

    // Lane 1 stalled: two beats fill it, third is held off.
    drive(0, 1, 2'd1, 8'h11, 4'b1101, 0); step();
    drive(0, 1, 2'd1, 8'h22, 4'b1101, 0); step();
    drive(0, 1, 2'd1, 8'h33, 4'b1101, 0); settle();
    chk("t2_full_block", ir4, 1'b0);
    chk("t2_head", od4[15:8], 8'h11);
    tick();
    drive(0, 1, 2'd1, 8'h33, 4'hF, 0); step();
    step();
    drive(0, 0, 0, 0, 4'hF, 0);
    repeat (3) step();

    // Interleaved lanes 0 and 3 with lane 3 stalled.
    drive(0, 1, 2'd0, 8'd1, 4'b0111, 0); step();
    drive(0, 1, 2'd3, 8'd2, 4'b0111, 0); step();
    drive(0, 1, 2'd0, 8'd3, 4'b0111, 0); step();
    drive(0, 1, 2'd3, 8'd4, 4'b0111, 0); step();
    drive(0, 0, 0, 0, 4'b0111, 0); step();
    drive(0, 0, 0, 0, 4'hF, 0);
    repeat (3) step();

    // Out-of-range drops on the 3-lane instance.
    drive(1, 1, 2'd3, 8'hEE, 4'hF, 0); step(); step();
    drive(1, 0, 0, 0, 4'hF, 0); settle();
    chk("t4_cnt2", dc3, 16'd2);
    chk("t4_sticky", es3, 1'b1);
    tick();
    drive(1, 1, 2'd3, 8'hEE, 4'hF, 1); step();
    drive(1, 0, 0, 0, 4'hF, 0); settle();
    chk("t4_cnt3", dc3, 16'd3);
    chk("t4_set_wins", es3, 1'b1);
    tick();
    drive(1, 0, 0, 0, 4'hF, 1); step();
    drive(1, 0, 0, 0, 4'hF, 0); settle();
    chk("t4_clr", es3, 1'b0);
    chk("t4_cnt_kept", dc3, 16'd3);
    tick();

    // Mid-stream asynchronous reset discards buffered beats.
    drive(0, 1, 2'd0, 8'h01, 4'h0, 0); step();
    drive(0, 1, 2'd0, 8'h02, 4'h0, 0); step();
    drive(0, 0, 0, 0, 4'h0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_ov", ov4, 4'h0);
    chk("t5_cnt", dc3, 16'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 2'd0, 8'h7E, 4'hF, 0); step();
    drive(0, 0, 0, 0, 4'hF, 0); step(); step();

    // Empty lane 2, consumer ready.
    drive(0, 1, 2'd2, 8'h5C, 4'hF, 0); settle();
`ifdef LANE_SCATTER_BYPASS_EN
    chk("t6_byp_data", od4[23:16], 8'h5C);
`else
    chk("t6_reg_ov", ov4[2], 1'b0);
`endif
    tick();
    drive(0, 0, 0, 0, 4'hF, 0); step(); step();

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++)
        drive(d, 1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
              4'($urandom), ($urandom_range(0, 7) == 0));
      step();
    end
    idle_all(4'hF);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_scatter.md
Name: lane_scatter

Overview:
- Write-side counterpart to the lane selectors that read from an indexed array of generate-loop instances.
- Takes a stream of beats, each tagged with a lane index, and routes each beat into a per-lane FIFO.
- Each lane presents its beat on its own valid/ready output.
- Sits between a single upstream producer and NUM_LANES replicated consumer instances.

Parameters:
- NUM_LANES, 4, number of output lanes (≥2).
- DATA_W, 8, beat payload width.
- DEPTH, 2, entries per lane FIFO (power of two, ≥2).
- Derived localparam IDX_W = $clog2(NUM_LANES), minimum 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  upstream beat accepted when in_valid&in_ready
- in_idx  input  IDX_W  destination lane
- in_data  input  DATA_W  payload
- out_valid  output  NUM_LANES  per-lane valid
- out_ready  input  NUM_LANES  per-lane ready
- out_data  output  NUM_LANES*DATA_W  lane k at [k*DATA_W +: DATA_W]
- err_clr  input  1  clears err_sticky
- drop_cnt  output  16  count of dropped (out-of-range) beats
- err_sticky  output  1  set on any drop

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. All FIFOs empty, out_valid=0, out_data=0, drop_cnt=0, err_sticky=0. Asserting rst_n mid-operation discards all buffered beats immediately. in_ready is combinational and is 1 during reset only if in_idx is out of range; upstream must not rely on handshakes during reset.
- in_ready: 1 if in_idx ≥ NUM_LANES, else !full[in_idx]. It depends on in_idx, not on in_valid.
  - A full lane blocks input even if that lane pops in the same cycle. No pass-through on full.
- Accept, in range: push in_data into FIFO[in_idx]. Per-lane order is preserved. Lanes are independent; a full lane never blocks beats to other lanes once in_idx changes.
- Accept, out of range (only possible for non-power-of-two NUM_LANES):
  - beat discarded;
  - drop_cnt += 1, saturating at 16'hFFFF;
  - err_sticky <= 1.
- err_clr:
  - clears err_sticky only; drop_cnt is cleared only by reset;
  - on the same cycle as a drop, set wins and err_sticky stays 1.
- Lane output:
  - out_valid[k] = FIFO[k] non-empty;
  - out_data slice = FIFO head, held stable while out_valid[k]&!out_ready[k];
  - pop on out_valid[k]&out_ready[k].
- Latency: accept in cycle N → out_valid visible in cycle N+1 (registered FIFO).
- Per-lane FIFO:
  - read/write pointers of width log2(DEPTH)+1; full when pointer MSBs differ and the rest match;
  - simultaneous push and pop on a non-full, non-empty lane keeps occupancy unchanged;
  - pointers wrap modulo 2*DEPTH.
- Throughput: one beat per cycle into any lane; one beat per cycle out of every lane concurrently.

Optional Feature:
- Macro LANE_SCATTER_BYPASS_EN.
- Defined: if the target lane FIFO is empty and out_ready[in_idx]=1, an accepted beat appears on out_data/out_valid combinationally in the same cycle and is not written to the FIFO. Latency becomes 0.
- Undefined: latency is always 1 cycle; outputs are pure register outputs.

Decomposition:
- Package lane_scatter_pkg:
  - localparam DROP_CNT_W=16;
  - function lane_idx_w(n) returning max(1,$clog2(n)).
- Sub-module lane_scatter_fifo(clk, rst_n, push, push_data, pop, full, empty, head_data), parameterised DATA_W/DEPTH.
- Instantiate lane_scatter_fifo in a generate loop, one per lane.
- Top level holds the index decode, drop counter and sticky flag.

Test Plan:
- Reset then single beat idx=2 data=8'hA5, all out_ready=1 → cycle+1 out_valid=4'b0100, lane2 data=A5; next cycle out_valid=0.
- Lane 1 out_ready=0; push 3 beats idx=1 (11,22,33), DEPTH=2 → first two accepted, in_ready=0 on third. Raise out_ready → lane delivers 11, then 22, then 33 accepted and delivered in order.
- Interleaved idx 0,3,0,3 with data 1..4 and lane 3 stalled → lane0 delivers 1,3 unaffected; lane3 later delivers 2,4.
- NUM_LANES=3, push idx=3 twice → both accepted, no out_valid, drop_cnt=2, err_sticky=1. err_clr on the same cycle as a third drop → err_sticky stays 1, drop_cnt=3.
- Fill lane0 with 2 beats, deassert rst_n mid-stream for 1 cycle → out_valid=0, drop_cnt=0 immediately. After release, push idx=0 data=7E → delivered alone.
- With LANE_SCATTER_BYPASS_EN: empty lane 2, out_ready=1, push 5C → out_valid[2]=1 and data 5C in the same cycle, FIFO stays empty. Without the macro, the same stimulus → output appears one cycle later.
